uart_tx: RTL and testbench

//   Serialises bytes onto the UART line: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.

---
 rtl/uart_tx.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// A one-entry holding register sits in front of the shifter so the next byte can queue mid-frame.
module uart_tx #(
    parameter int unsigned CLOCK_FREQUENCY = 12_000_000,
    parameter int unsigned BAUD_RATE       = 115_200,
    parameter int unsigned PARITY_BIT      = 0,
    parameter int unsigned STOP_BITS       = 1
) (
    input  logic       uart_clk,
    input  logic       reset_n,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       uart_out,
    output logic       busy,
    output logic       frame_done_strobe
);

    localparam int unsigned ClocksPerBaud = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int unsigned CntW = (ClocksPerBaud < 2) ? 1 : $clog2(ClocksPerBaud);
    localparam logic [CntW-1:0] BaudLoad = CntW'(ClocksPerBaud - 1);
    localparam logic [3:0] LastStop = 4'(STOP_BITS - 1);
    localparam bit HasParity = (PARITY_BIT != 0);

    if (ClocksPerBaud < 2) begin : g_bad_baud
        $error("uart_tx: CLOCK_FREQUENCY / BAUD_RATE must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY_BIT > 2) begin : g_bad_parity
        $error("uart_tx: PARITY_BIT must be 0, 1 or 2");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] baud_q, baud_d;
    logic [3:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic            out_q, out_d;
    logic            strobe_q, strobe_d;
    logic            hold_full_q, hold_full_d;
    logic [7:0]      hold_q, hold_d;
    logic            load;
    logic            baud_done;

    assign baud_done = (baud_q == '0);

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        out_d       = out_q;
        strobe_d    = 1'b0;
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        load        = 1'b0;

        unique case (state_q)
            StIdle: begin
                out_d = 1'b1;
                load  = hold_full_q;
            end
            StStart: begin
                if (baud_done) begin
                    state_d = StData;
                    bit_d   = 4'd0;
                    baud_d  = BaudLoad;
                    out_d   = shift_q[0];
                end else begin
                    baud_d = baud_q - CntW'(1);
                end
            end
            StData: begin
                if (baud_done) begin
                    baud_d = BaudLoad;
                    if (bit_q == 4'd7) begin
                        bit_d = 4'd0;
                        if (HasParity) begin
                            state_d = StParity;
                            out_d   = parity_q;
                        end else begin
                            state_d = StStop;
                            out_d   = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        shift_d = shift_q >> 1;
                        out_d   = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - CntW'(1);
                end
            end
            StParity: begin
                if (baud_done) begin
                    state_d = StStop;
                    bit_d   = 4'd0;
                    baud_d  = BaudLoad;
                    out_d   = 1'b1;
                end else begin
                    baud_d = baud_q - CntW'(1);
                end
            end
            StStop: begin
                if (baud_done) begin
                    if (bit_q == LastStop) begin
                        strobe_d = 1'b1;
                        // A queued byte starts at once: no idle gap between frames.
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = StIdle;
                            out_d   = 1'b1;
                        end
                    end else begin
                        bit_d  = bit_q + 4'd1;
                        baud_d = BaudLoad;
                    end
                end else begin
                    baud_d = baud_q - CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                out_d   = 1'b1;
            end
        endcase

        if (load) begin
            shift_d     = hold_q;
            parity_d    = (PARITY_BIT == 2) ? ~^hold_q : ^hold_q;
            hold_full_d = 1'b0;
            state_d     = StStart;
            baud_d      = BaudLoad;
            bit_d       = 4'd0;
            out_d       = 1'b0;
        end

        // Load needs a full register and accept an empty one, so they never collide.
        if (data_valid && !hold_full_q) begin
            hold_full_d = 1'b1;
            hold_d      = data;
        end
    end

    always_ff @(posedge uart_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            baud_q      <= '0;
            bit_q       <= 4'd0;
            shift_q     <= 8'd0;
            parity_q    <= 1'b0;
            out_q       <= 1'b1;
            strobe_q    <= 1'b0;
            hold_full_q <= 1'b0;
            hold_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            out_q       <= out_d;
            strobe_q    <= strobe_d;
            hold_full_q <= hold_full_d;
            hold_q      <= hold_d;
        end
    end

    assign data_ready        = ~hold_full_q;
    assign uart_out          = out_q;
    assign busy              = (state_q != StIdle) | hold_full_q;
    assign frame_done_strobe = strobe_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: six framing configurations share one stimulus stream and are checked
// every cycle against a frame-position model, plus literal spot checks on chosen cycles.
module tb_uart_tx;

    localparam int NI = 6;
    localparam int unsigned CLK_HZ = 12_000_000;

    function automatic int unsigned cfg_br(int g);
        case (g)
            4:       return 3_000_000;
            5:       return 6_000_000;
            default: return 115_200;
        endcase
    endfunction

    function automatic int unsigned cfg_par(int g);
        case (g)
            1, 4:    return 1;
            2, 5:    return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned cfg_stop(int g);
        case (g)
            3, 4:    return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int cfg_cpb(int g);
        return int'(CLK_HZ / cfg_br(g));
    endfunction

    function automatic int flen(int g);
        return (9 + ((cfg_par(g) != 0) ? 1 : 0) + int'(cfg_stop(g))) * cfg_cpb(g);
    endfunction

    // Line level at frame offset t: slot 0 start, 1..8 data LSB first, optional parity, stops.
    function automatic logic exp_bit(int g, logic [7:0] b, int t);
        int idx;
        idx = t / cfg_cpb(g);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (cfg_par(g) != 0 && idx == 9) return (cfg_par(g) == 1) ? ^b : ~^b;
        return 1'b1;
    endfunction

    logic          clk;
    logic          rst_n;
    logic [7:0]    data;
    logic          data_valid;
    logic [NI-1:0] ready_w, line_w, busy_w, strobe_w;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_tx #(
            .CLOCK_FREQUENCY(CLK_HZ),
            .BAUD_RATE      (cfg_br(g)),
            .PARITY_BIT     (cfg_par(g)),
            .STOP_BITS      (cfg_stop(g))
        ) u_dut (
            .uart_clk         (clk),
            .reset_n          (rst_n),
            .data             (data),
            .data_valid       (data_valid),
            .data_ready       (ready_w[g]),
            .uart_out         (line_w[g]),
            .busy             (busy_w[g]),
            .frame_done_strobe(strobe_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    bit         m_active[NI];
    int         m_t[NI];
    logic [7:0] m_byte[NI];
    bit         m_hold[NI];
    logic [7:0] m_hb[NI];
    bit         m_strobe[NI];

    initial begin : model
        bit oh;
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < NI; i++) begin
                if (!rst_n) begin
                    m_active[i] = 0; m_t[i] = 0; m_hold[i] = 0; m_strobe[i] = 0;
                end else begin
                    oh = m_hold[i];
                    m_strobe[i] = 0;
                    if (m_active[i]) begin
                        m_t[i]++;
                        if (m_t[i] == flen(i)) begin
                            m_strobe[i] = 1;
                            if (oh) begin
                                m_byte[i] = m_hb[i]; m_t[i] = 0; m_hold[i] = 0;
                            end else begin
                                m_active[i] = 0;
                            end
                        end
                    end else if (oh) begin
                        m_active[i] = 1; m_t[i] = 0; m_byte[i] = m_hb[i]; m_hold[i] = 0;
                    end
                    if (data_valid && !oh) begin
                        m_hold[i] = 1; m_hb[i] = data;
                    end
                end
            end
        end
    end

    initial begin : compare
        logic el, er, eb, es;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                el = m_active[i] ? exp_bit(i, m_byte[i], m_t[i]) : 1'b1;
                er = !m_hold[i];
                eb = m_active[i] || m_hold[i];
                es = m_strobe[i];
                tests++;
                if ({line_w[i], ready_w[i], busy_w[i], strobe_w[i]} !== {el, er, eb, es}) begin
                    fails++;
                    $display("FAIL model inst%0d t=%0t: line/ready/busy/strobe got %b%b%b%b want %b%b%b%b",
                             i, $time, line_w[i], ready_w[i], busy_w[i], strobe_w[i],
                             el, er, eb, es);
                end
            end
        end
    end

    task automatic check(string name, int got, int want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle k=0 (accept edge E0 just passed).
    task automatic send(logic [7:0] b);
        data = b;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_w != '0 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_busy", int'(busy_w), 0);
        @(negedge clk);
    endtask

    bit pat55[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

    initial begin : stim
        int e_line, e_str, hi_run, rises;
        logic want, prev_rdy;
        rst_n = 1'b0;
        data = 8'h00;
        data_valid = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset_line%0d", i), int'(line_w[i]), 1);
            check($sformatf("reset_ready%0d", i), int'(ready_w[i]), 1);
            check($sformatf("reset_busy%0d", i), int'(busy_w[i]), 0);
        end
        #2 rst_n = 1'b1;
        @(negedge clk);

        // 0x55 at defaults: alternating line, strobe only at cycle 1041.
        send(8'h55);
        e_line = 0;
        e_str = 0;
        for (int k = 1; k <= 1045; k++) begin
            @(negedge clk);
            want = (k <= 1040) ? logic'(pat55[(k - 1) / 104]) : 1'b1;
            if (line_w[0] !== want) e_line++;
            if (strobe_w[0] !== (k == 1041)) e_str++;
        end
        check("frame55_line_errors", e_line, 0);
        check("frame55_strobe_errors", e_str, 0);
        wait_idle();

        // 0x07: even parity 1, odd parity 0, 1144-cycle frames.
        send(8'h07);
        for (int k = 1; k <= 1145; k++) begin
            @(negedge clk);
            if (k == 988) begin
                check("even_parity_07", int'(line_w[1]), 1);
                check("odd_parity_07", int'(line_w[2]), 0);
            end
            if (k == 1144) check("par_strobe_early", int'(strobe_w[1]), 0);
            if (k == 1145) begin
                check("even_frame_end", int'(strobe_w[1]), 1);
                check("odd_frame_end", int'(strobe_w[2]), 1);
            end
        end
        wait_idle();

        // Two stop bits, valid held: 0xA5 then 0x3C back to back.
        data = 8'hA5;
        data_valid = 1'b1;
        @(negedge clk);
        check("b2b_ready_k0", int'(ready_w[3]), 0);
        data = 8'h3C;
        @(negedge clk);
        check("b2b_ready_k1", int'(ready_w[3]), 1);
        @(negedge clk);
        data_valid = 1'b0;
        check("b2b_ready_k2", int'(ready_w[3]), 0);
        hi_run = 0;
        rises = 0;
        prev_rdy = ready_w[3];
        for (int k = 3; k <= 1150; k++) begin
            @(negedge clk);
            if (k >= 937 && k <= 1144 && line_w[3] === 1'b1) hi_run++;
            if (k == 1145) begin
                check("b2b_second_start", int'(line_w[3]), 0);
                check("b2b_strobe", int'(strobe_w[3]), 1);
            end
            if (ready_w[3] && !prev_rdy) rises++;
            prev_rdy = ready_w[3];
        end
        check("b2b_stop_high_cycles", hi_run, 208);
        check("b2b_ready_rises", rises, 1);
        wait_idle();

        // Accept 0xFF on the last stop-bit edge: one idle cycle, then start.
        send(8'h00);
        for (int k = 1; k <= 1042; k++) begin
            @(negedge clk);
            if (k == 1040) begin
                data = 8'hFF;
                data_valid = 1'b1;
            end
            if (k == 1041) begin
                data_valid = 1'b0;
                check("edge_idle_line", int'(line_w[0]), 1);
                check("edge_strobe", int'(strobe_w[0]), 1);
                check("edge_ready", int'(ready_w[0]), 0);
            end
            if (k == 1042) check("edge_start_line", int'(line_w[0]), 0);
        end
        wait_idle();

        // Reset in the middle of 0x00's data bits.
        send(8'h00);
        repeat (300) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("midreset_line%0d", i), int'(line_w[i]), 1);
            check($sformatf("midreset_ready%0d", i), int'(ready_w[i]), 1);
            check($sformatf("midreset_busy%0d", i), int'(busy_w[i]), 0);
            check($sformatf("midreset_strobe%0d", i), int'(strobe_w[i]), 0);
        end
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        send(8'h81);
        for (int k = 1; k <= 884; k++) begin
            @(negedge clk);
            if (k == 157) check("after_reset_bit0", int'(line_w[0]), 1);
            if (k == 261) check("after_reset_bit1", int'(line_w[0]), 0);
            if (k == 884) check("after_reset_bit7", int'(line_w[0]), 1);
        end
        wait_idle();

        // Data input churns while 0x3C is in flight.
        send(8'h3C);
        for (int k = 1; k <= 1100; k++) begin
            @(negedge clk);
            data = 8'($urandom);
            if (k == 260) check("churn_bit1", int'(line_w[0]), 0);
            if (k == 364) check("churn_bit2", int'(line_w[0]), 1);
        end
        wait_idle();

        // Random traffic with occasional resets.
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            data = 8'($urandom);
            data_valid = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3999) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        data_valid = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
